// File: rtl/memoria_dados_pkg.sv
// Shared types and constants for the data-memory arbiter.
package memoria_dados_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    localparam int PROFUNDIDADE_PADRAO = 20;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    function automatic logic [1:0] um_quente(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Combinational two-way round-robin picker.
module arbitro_rr2
    import memoria_dados_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ponteiro,
    output logic       valido,
    output logic       vencedor
);

    always_comb begin
        valido   = |req;
        vencedor = REQ_CPU;
        unique case (req)
            2'b01:   vencedor = REQ_CPU;
            2'b10:   vencedor = REQ_DMA;
            2'b11:   vencedor = ponteiro;
            default: vencedor = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Round-robin arbiter and single-access sequencer for the data memory.
module arbitro_memoria_dados
    import memoria_dados_pkg::*;
#(
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int LARGURA      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           Req,
    input  logic [1:0]           Escrita,
    input  logic [2*LARGURA-1:0] Endereco,
    input  logic [2*LARGURA-1:0] DadoEscrita,
    output logic [1:0]           Ack,
    output logic [1:0]           Erro,
    output logic [LARGURA-1:0]   DadoLido,
    output logic [LARGURA-1:0]   MemEndereco,
    output logic [LARGURA-1:0]   MemDadoEscrita,
    output logic                 MemFlagEscrita,
    input  logic [LARGURA-1:0]   MemDadoLeitura
);

    estado_t              estado;
    estado_t              proximo;
    logic                 ponteiro;
    logic                 indice;
    logic                 valido;
    logic                 vencedor;
    logic [1:0]           mascara;
    logic [1:0]           req_efetivo;
    logic                 escrita_lat;
    logic [LARGURA-1:0]   endereco_lat;
    logic [LARGURA-1:0]   dado_lat;
    logic [LARGURA-1:0]   dado_lido_r;
    logic                 fora;

    // The requester just acked still holds Req for one more cycle.
    assign req_efetivo = Req & ~mascara;
    assign fora        = endereco_lat >= LARGURA'(PROFUNDIDADE);
    assign DadoLido    = dado_lido_r;

    arbitro_rr2 u_rr (
        .req      (req_efetivo),
        .ponteiro (ponteiro),
        .valido   (valido),
        .vencedor (vencedor)
    );

    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO:   if (valido) proximo = ACESSO;
            ACESSO:   proximo = RESPOSTA;
            RESPOSTA: proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    always_comb begin
        MemEndereco    = '0;
        MemDadoEscrita = '0;
        MemFlagEscrita = 1'b0;
        Ack            = '0;
        Erro           = '0;
        if (estado == ACESSO) begin
            MemEndereco    = fora ? '0 : endereco_lat;
            MemDadoEscrita = dado_lat;
            MemFlagEscrita = escrita_lat & ~fora & ~reset;
        end
        if (estado == RESPOSTA) begin
            Ack  = um_quente(indice);
            Erro = fora ? um_quente(indice) : 2'b00;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            ponteiro     <= REQ_CPU;
            indice       <= REQ_CPU;
            mascara      <= '0;
            escrita_lat  <= 1'b0;
            endereco_lat <= '0;
            dado_lat     <= '0;
            dado_lido_r  <= '0;
        end else begin
            estado  <= proximo;
            mascara <= (estado == RESPOSTA) ? Ack : 2'b00;
            if (estado == OCIOSO && valido) begin
                indice       <= vencedor;
                ponteiro     <= ~vencedor;
                escrita_lat  <= Escrita[vencedor];
                endereco_lat <= vencedor ? Endereco[2*LARGURA-1:LARGURA]
                                         : Endereco[LARGURA-1:0];
                dado_lat     <= vencedor ? DadoEscrita[2*LARGURA-1:LARGURA]
                                         : DadoEscrita[LARGURA-1:0];
            end
            if (estado == ACESSO)
                dado_lido_r <= fora ? '0 : MemDadoLeitura;
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados with a falling-edge memory model.
module tb_arbitro_memoria_dados;

    logic        clock;
    logic        reset;
    logic [1:0]  Req;
    logic [1:0]  Escrita;
    logic [63:0] Endereco;
    logic [63:0] DadoEscrita;
    logic [1:0]  Ack;
    logic [1:0]  Erro;
    logic [31:0] DadoLido;
    logic [31:0] MemEndereco;
    logic [31:0] MemDadoEscrita;
    logic        MemFlagEscrita;
    logic [31:0] MemDadoLeitura;

    logic [31:0] mem     [0:19];
    logic [31:0] exp_mem [0:19];

    int total;
    int passed;

    arbitro_memoria_dados #(
        .PROFUNDIDADE (20),
        .LARGURA      (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .Req            (Req),
        .Escrita        (Escrita),
        .Endereco       (Endereco),
        .DadoEscrita    (DadoEscrita),
        .Ack            (Ack),
        .Erro           (Erro),
        .DadoLido       (DadoLido),
        .MemEndereco    (MemEndereco),
        .MemDadoEscrita (MemDadoEscrita),
        .MemFlagEscrita (MemFlagEscrita),
        .MemDadoLeitura (MemDadoLeitura)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: write then read-after-write on the falling edge
    always @(negedge clock) begin
        if (MemFlagEscrita && MemEndereco < 32'd20)
            mem[MemEndereco[4:0]] = MemDadoEscrita;
        if (MemEndereco < 32'd20)
            MemDadoLeitura = mem[MemEndereco[4:0]];
        else
            MemDadoLeitura = '0;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic executa(input int idx, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output int nflag,
                           output logic erro, output logic [31:0] lido,
                           output logic [31:0] mend);
        lat   = -1;
        nflag = 0;
        erro  = 1'b0;
        lido  = '0;
        mend  = '1;
        Req[idx]                 = 1'b1;
        Escrita[idx]             = wr;
        Endereco[idx*32 +: 32]   = addr;
        DadoEscrita[idx*32 +: 32] = data;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            step();
            if (MemFlagEscrita) nflag++;
            if (c == 1) begin
                mend = MemEndereco;
                Endereco[idx*32 +: 32]    = addr ^ 32'h2;
                DadoEscrita[idx*32 +: 32] = ~data;
            end
            if (Ack[idx]) begin
                lat  = c;
                erro = Erro[idx];
                lido = DadoLido;
            end
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (MemFlagEscrita) nflag++;
        end
        Req[idx] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (Ack !== 2'b00) $display("FAIL reset_ack got %b exp 00", Ack); else passed++;
        total++; if (Erro !== 2'b00) $display("FAIL reset_erro got %b exp 00", Erro); else passed++;
        total++; if (DadoLido !== 32'h0) $display("FAIL reset_lido got %h exp 0", DadoLido); else passed++;
        total++; if (MemEndereco !== 32'h0) $display("FAIL reset_mend got %h exp 0", MemEndereco); else passed++;
        total++; if (MemDadoEscrita !== 32'h0) $display("FAIL reset_mdado got %h exp 0", MemDadoEscrita); else passed++;
        total++; if (MemFlagEscrita !== 1'b0) $display("FAIL reset_flag got %b exp 0", MemFlagEscrita); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_idle();
        Req = 2'b00;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (Ack !== 2'b00 || MemFlagEscrita !== 1'b0)
                $display("FAIL idle_c%0d got ack=%b flag=%b exp 00/0", c, Ack, MemFlagEscrita);
            else passed++;
        end
    endtask

    task automatic test_store_load();
        int lat, nflag;
        logic erro;
        logic [31:0] lido, mend;
        executa(0, 1'b1, 32'd5, 32'hDEADBEEF, lat, nflag, erro, lido, mend);
        exp_mem[5] = 32'hDEADBEEF;
        total++; if (lat !== 2) $display("FAIL st_lat got %0d exp 2", lat); else passed++;
        total++; if (nflag !== 1) $display("FAIL st_flag_cycles got %0d exp 1", nflag); else passed++;
        total++; if (erro !== 1'b0) $display("FAIL st_erro got %b exp 0", erro); else passed++;
        total++; if (lido !== 32'hDEADBEEF) $display("FAIL st_lido got %h exp deadbeef", lido); else passed++;
        total++; if (mend !== 32'd5) $display("FAIL st_mend got %h exp 5", mend); else passed++;
        total++; if (mem[5] !== 32'hDEADBEEF) $display("FAIL st_mem5 got %h exp deadbeef", mem[5]); else passed++;
        executa(0, 1'b0, 32'd5, 32'h0, lat, nflag, erro, lido, mend);
        total++; if (lat !== 2) $display("FAIL ld_lat got %0d exp 2", lat); else passed++;
        total++; if (nflag !== 0) $display("FAIL ld_flag_cycles got %0d exp 0", nflag); else passed++;
        total++; if (lido !== 32'hDEADBEEF) $display("FAIL ld_lido got %h exp deadbeef", lido); else passed++;
    endtask

    task automatic test_boundary();
        int lat, nflag;
        logic erro;
        logic [31:0] lido, mend;
        executa(0, 1'b1, 32'd19, 32'hCAFEF00D, lat, nflag, erro, lido, mend);
        exp_mem[19] = 32'hCAFEF00D;
        total++; if (erro !== 1'b0) $display("FAIL b19_erro got %b exp 0", erro); else passed++;
        total++; if (nflag !== 1) $display("FAIL b19_flag_cycles got %0d exp 1", nflag); else passed++;
        total++; if (mem[19] !== 32'hCAFEF00D) $display("FAIL b19_mem got %h exp cafef00d", mem[19]); else passed++;
        executa(1, 1'b0, 32'd19, 32'h0, lat, nflag, erro, lido, mend);
        total++; if (lat !== 2) $display("FAIL b19_ld_lat got %0d exp 2", lat); else passed++;
        total++; if (lido !== 32'hCAFEF00D) $display("FAIL b19_ld_lido got %h exp cafef00d", lido); else passed++;
    endtask

    task automatic test_contention();
        int n;
        int t [4];
        logic w [4];
        logic [31:0] d [4];
        logic [31:0] exp_d;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        Req      = 2'b11;
        Escrita  = 2'b00;
        Endereco = {32'd19, 32'd5};
        for (int c = 1; c <= 12; c++) begin
            step();
            if (Ack !== 2'b00 && n < 4) begin
                t[n] = c;
                w[n] = Ack[1];
                d[n] = DadoLido;
                n++;
            end
        end
        Req = 2'b00;
        step();
        step();
        total++; if (n !== 4) $display("FAIL rr_count got %0d exp 4", n); else passed++;
        for (int k = 0; k < 4 && k < n; k++) begin
            exp_d = (k % 2 == 1) ? 32'hCAFEF00D : 32'hDEADBEEF;
            total++;
            if (t[k] !== 2 + 3 * k)
                $display("FAIL rr_time%0d got %0d exp %0d", k, t[k], 2 + 3 * k);
            else passed++;
            total++;
            if (w[k] !== (k % 2 == 1))
                $display("FAIL rr_winner%0d got %0d exp %0d", k, w[k], k % 2);
            else passed++;
            total++;
            if (d[k] !== exp_d)
                $display("FAIL rr_lido%0d got %h exp %h", k, d[k], exp_d);
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        int lat, nflag;
        logic erro;
        logic [31:0] lido, mend;
        logic [31:0] addrs [2];
        addrs[0] = 32'd20;
        addrs[1] = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            executa(1, 1'b1, addrs[k], 32'h1234, lat, nflag, erro, lido, mend);
            total++; if (lat !== 2) $display("FAIL oor%0d_lat got %0d exp 2", k, lat); else passed++;
            total++; if (erro !== 1'b1) $display("FAIL oor%0d_erro got %b exp 1", k, erro); else passed++;
            total++; if (nflag !== 0) $display("FAIL oor%0d_flag got %0d exp 0", k, nflag); else passed++;
            total++; if (lido !== 32'h0) $display("FAIL oor%0d_lido got %h exp 0", k, lido); else passed++;
            total++; if (mend !== 32'h0) $display("FAIL oor%0d_mend got %h exp 0", k, mend); else passed++;
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (mem[i] !== exp_mem[i])
                $display("FAIL oor_mem%0d got %h exp %h", i, mem[i], exp_mem[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        Req[0]               = 1'b1;
        Escrita[0]           = 1'b1;
        Endereco[31:0]       = 32'd3;
        DadoEscrita[31:0]    = 32'hAAAA;
        step();
        total++; if (MemFlagEscrita !== 1'b1) $display("FAIL rma_launch_flag got %b exp 1", MemFlagEscrita); else passed++;
        reset = 1'b1;
        #1;
        total++; if (MemFlagEscrita !== 1'b0) $display("FAIL rma_flag_forced got %b exp 0", MemFlagEscrita); else passed++;
        step();
        total++; if (Ack !== 2'b00) $display("FAIL rma_ack got %b exp 00", Ack); else passed++;
        total++; if (DadoLido !== 32'h0) $display("FAIL rma_lido got %h exp 0", DadoLido); else passed++;
        total++; if (MemEndereco !== 32'h0) $display("FAIL rma_mend got %h exp 0", MemEndereco); else passed++;
        total++; if (MemDadoEscrita !== 32'h0) $display("FAIL rma_mdado got %h exp 0", MemDadoEscrita); else passed++;
        Req   = 2'b00;
        reset = 1'b0;
        acks  = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (Ack !== 2'b00) acks++;
        end
        total++; if (acks !== 0) $display("FAIL rma_no_ack got %0d exp 0", acks); else passed++;
        total++; if (mem[3] !== exp_mem[3]) $display("FAIL rma_mem3 got %h exp %h", mem[3], exp_mem[3]); else passed++;
    endtask

    initial begin
        total          = 0;
        passed         = 0;
        reset          = 1'b1;
        Req            = 2'b00;
        Escrita        = 2'b00;
        Endereco       = '0;
        DadoEscrita    = '0;
        MemDadoLeitura = '0;
        for (int i = 0; i < 20; i++) begin
            mem[i]     = 32'h1000 + i;
            exp_mem[i] = 32'h1000 + i;
        end
        test_reset();
        test_idle();
        test_store_load();
        test_boundary();
        test_contention();
        test_out_of_range();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
